// File: rtl/alu_pkg.sv
// Shared types for the ALU issue sequencer: flag bundle, opcode encoding, FSM states.
package alu_pkg;

  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
  } ALUFlagsStruct;

  typedef enum logic [3:0] {
    AND = 4'h0,
    OR  = 4'h1,
    ADD = 4'h2,
    INC = 4'h3,
    DEC = 4'h4,
    NOT = 4'h5,
    SUB = 4'h6,
    XOR = 4'h7,
    SHL = 4'h8,
    SHR = 4'h9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'h9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EXEC,
    RESP
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU driven by the sequencer; ADD consumes ALUFlagIn as carry-in.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]    ALUA,
  input  logic [3:0]    ALUB,
  input  logic [3:0]    ALUControl,
  input  logic          ALUFlagIn,
  output logic [3:0]    ALUResult,
  output ALUFlagsStruct ALUFlags
);

  logic [4:0] sum;
  logic [3:0] r;
  logic       c, v;

  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (alu_op_e'(ALUControl))
      AND: r = ALUA & ALUB;
      OR:  r = ALUA | ALUB;
      ADD: begin
        sum = {1'b0, ALUA} + {1'b0, ALUB} + {4'b0, ALUFlagIn};
        r = sum[3:0]; c = sum[4];
        v = (ALUA[3] == ALUB[3]) && (r[3] != ALUA[3]);
      end
      INC: begin
        sum = {1'b0, ALUA} + 5'd1;
        r = sum[3:0]; c = sum[4];
        v = !ALUA[3] && r[3];
      end
      DEC: begin
        sum = {1'b0, ALUA} + 5'h0F;
        r = sum[3:0]; c = sum[4];
        v = ALUA[3] && !r[3];
      end
      NOT: r = ~ALUA;
      SUB: begin
        sum = {1'b0, ALUA} + {1'b0, ~ALUB} + 5'd1;
        r = sum[3:0]; c = sum[4];
        v = (ALUA[3] != ALUB[3]) && (r[3] != ALUA[3]);
      end
      XOR: r = ALUA ^ ALUB;
      SHL: begin r = {ALUA[2:0], 1'b0}; c = ALUA[3]; end
      SHR: begin r = {1'b0, ALUA[3:1]}; c = ALUA[0]; end
      default: r = '0;
    endcase
  end

  assign ALUResult = r;
  assign ALUFlags  = '{N: r[3], Z: (r == 4'h0), C: c, V: v};

endmodule

// File: rtl/alu_seq_regfile.sv
// Local operand store: two async read ports, one sync write port shared by preload and writeback.
module alu_seq_regfile #(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [RW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             wb_en,
  input  logic [RW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [RW-1:0]    addr_a,
  input  logic [RW-1:0]    addr_b,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b
);

  logic [NREGS-1:0][WIDTH-1:0] mem;
  logic                        we;
  logic [RW-1:0]               waddr;
  logic [WIDTH-1:0]            wdata;

  // Writeback and preload never coincide; writeback still wins if they ever did.
  always_comb begin
    we    = wb_en | ld_en;
    waddr = wb_en ? wb_addr : ld_addr;
    wdata = wb_en ? wb_data : ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst)     mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Issue side of the external ALU: latch instruction, drive registered operands, capture and return result.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [RW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [RW-1:0]    instr_rd,
  input  logic [RW-1:0]    instr_rs1,
  input  logic [RW-1:0]    instr_rs2,
  input  logic             instr_cin,
  output logic [WIDTH-1:0] ALUA,
  output logic [WIDTH-1:0] ALUB,
  output logic [3:0]       ALUControl,
  output logic             ALUFlagIn,
  input  logic [WIDTH-1:0] ALUResult,
  input  ALUFlagsStruct    ALUFlags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output ALUFlagsStruct    res_flags,
  output logic [RW-1:0]    res_rd,
  output logic             res_err,
  output logic             busy
);

  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          cin;
  } instr_t;

  seq_state_e       state, next;
  instr_t           ins;
  logic             carry, fire, illegal;
  logic [WIDTH-1:0] rf_a, rf_b;

  assign fire    = instr_valid & instr_ready;
  assign illegal = instr_op > ALU_OP_MAX;

  alu_seq_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (ld_en && state == IDLE),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wb_en   (state == EXEC),
    .wb_addr (ins.rd),
    .wb_data (ALUResult),
    .addr_a  (ins.rs1),
    .addr_b  (ins.rs2),
    .data_a  (rf_a),
    .data_b  (rf_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (fire) next = illegal ? RESP : ISSUE;
      ISSUE:   next = EXEC;
      EXEC:    next = RESP;
      RESP:    if (res_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE) && !ld_en;
    busy        = (state != IDLE);
  end

  // Operands are sampled in ISSUE, so a same-register rd sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ins        <= '0;
      carry      <= 1'b0;
      ALUA       <= '0;
      ALUB       <= '0;
      ALUControl <= '0;
      ALUFlagIn  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_flags  <= '0;
      res_rd     <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          ins <= '{op: instr_op, rd: instr_rd, rs1: instr_rs1, rs2: instr_rs2, cin: instr_cin};
          if (illegal) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= '0;
            res_flags <= '0;
            res_rd    <= instr_rd;
          end
        end
        ISSUE: begin
          ALUA       <= rf_a;
          ALUB       <= rf_b;
          ALUControl <= ins.op;
          ALUFlagIn  <= ins.cin & carry;
        end
        EXEC: begin
          carry     <= ALUFlags.C;
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          res_data  <= ALUResult;
          res_flags <= ALUFlags;
          res_rd    <= ins.rd;
        end
        RESP: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
